sram_nr1w: RTL and testbench

SRAM_NR1W -- requirements
Module: sram_nr1w

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_nr1w_if.sv | 39 +++
 rtl/sram_rd_pipe.sv | 48 ++++
 rtl/sram_nr1w.sv | 121 ++++++++++++
 tb/tb_sram_nr1w.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the sram_nr1w multi-read-port memory:
//   state_t     - controller state (ST_INIT while sweeping zeros, ST_RUN after)
//   DATA_W_DEF  - default word width
//   ADDR_W_DEF  - default address width
//   depth_of()  - number of words for a given address width
// ---------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 13;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sram_nr1w_if.sv
// ---------------------------------------------------------------------------
// sram_nr1w_if
// Bus bundle for sram_nr1w: one write port, N_RD read ports, ready status.
//   ready    - memory initialised, requests accepted
//   wr_en    - write strobe, wr_addr / wr_data
//   rd_en    - per-port read strobe
//   rd_addr  - packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  - packed read data,      port i at [i*DATA_W +: DATA_W]
//   rd_valid - per-port one-cycle data-valid pulse
// Modports: master (requester side), slave (memory side).
// ---------------------------------------------------------------------------
interface sram_nr1w_if
  import sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_RD   = 2
);

  logic                     ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [N_RD-1:0]          rd_en;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic [N_RD*DATA_W-1:0]   rd_data;
  logic [N_RD-1:0]          rd_valid;

  modport master (
    input  ready, rd_data, rd_valid,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

  modport slave (
    output ready, rd_data, rd_valid,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

endinterface

// File: rtl/sram_rd_pipe.sv
// ---------------------------------------------------------------------------
// sram_rd_pipe
// Latency pipeline for one read port: RD_LAT register stages carrying a
// valid bit and the word read from the array. Data stages only load when
// the stage feeding them is valid, so the output word holds its last value
// between pulses.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset, clears valids and data
//   i_vld   - read accepted this cycle
//   i_data  - word read from the array this cycle
//   o_vld   - one-cycle pulse RD_LAT cycles after i_vld
//   o_data  - delayed word
// ---------------------------------------------------------------------------
module sram_rd_pipe #(
  parameter int DATA_W = 128,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data
);

  // Stage s of the pipeline: index 0 is the array capture, RD_LAT-1 the output
  logic [RD_LAT-1:0] r_vld_p;
  logic [DATA_W-1:0] r_data_p [RD_LAT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p <= '0;
      for (int s = 0; s < RD_LAT; s++) r_data_p[s] <= '0;
    end else begin
      r_vld_p[0] <= i_vld;
      if (i_vld) r_data_p[0] <= i_data;
      for (int s = 1; s < RD_LAT; s++) begin
        r_vld_p[s] <= r_vld_p[s-1];
        if (r_vld_p[s-1]) r_data_p[s] <= r_data_p[s-1];
      end
    end
  end

  assign o_vld  = r_vld_p[RD_LAT-1];
  assign o_data = r_data_p[RD_LAT-1];

endmodule

// File: rtl/sram_nr1w.sv
// ---------------------------------------------------------------------------
// sram_nr1w
// 2**ADDR_W x DATA_W memory with one write port and N_RD independent,
// fully pipelined read ports of latency RD_LAT. After reset the controller
// sweeps zeros through every address (one per cycle) before raising ready;
// the array itself has no reset.
// Ports:
//   clock   - sole clock, rising edge
//   reset_n - asynchronous active-low reset (controller + read pipelines)
//   bus     - sram_nr1w_if.slave (ready, write port, read ports)
// Build option:
//   SRAM_NR1W_BYPASS_EN - when defined, a read of the address being written
//                         in the same cycle returns the new write data;
//                         otherwise it returns the pre-write contents.
// ---------------------------------------------------------------------------
module sram_nr1w
  import sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_RD   = 2,
  parameter int RD_LAT = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  sram_nr1w_if.slave   bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  state_t              r_state;
  state_t              w_state_nxt;
  // One extra bit: the MSB set means every address has been cleared
  logic [ADDR_W:0]     r_init_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_run;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  wire  [N_RD-1:0]        w_rd_vld;
  wire  [N_RD*DATA_W-1:0] w_rd_data;

  assign w_run = (r_state == ST_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT && !r_init_cnt[ADDR_W])
        r_init_cnt <= r_init_cnt + (ADDR_W+1)'(1);
    end
  end

  // Next state and array write selection. The cycle after the last address
  // is cleared is spent with no write, then RUN is entered.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.wr_addr;
    w_mem_wdata = bus.wr_data;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt[ADDR_W]) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_init_cnt[ADDR_W-1:0];
          w_mem_wdata = '0;
        end
      end
      ST_RUN: begin
        w_mem_we = bus.wr_en;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Read ports: array look-up this cycle, captured by the first pipe stage
  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rword;
    logic              w_req;

    assign w_raddr = bus.rd_addr[gi*ADDR_W +: ADDR_W];
    assign w_req   = bus.rd_en[gi] & w_run;

`ifdef SRAM_NR1W_BYPASS_EN
    assign w_rword = (w_run && bus.wr_en && (bus.wr_addr == w_raddr)) ?
                     bus.wr_data : r_mem[w_raddr];
`else
    assign w_rword = r_mem[w_raddr];
`endif

    sram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
    ) u_pipe (
      .clock   (clock),
      .reset_n (reset_n),
      .i_vld   (w_req),
      .i_data  (w_rword),
      .o_vld   (w_rd_vld[gi]),
      .o_data  (w_rd_data[gi*DATA_W +: DATA_W])
    );
  end

  assign bus.ready    = w_run;
  assign bus.rd_valid = w_rd_vld;
  assign bus.rd_data  = w_rd_data;

endmodule

// File: tb/tb_sram_nr1w.sv
module tb_sram_nr1w;

  localparam int DW    = 128;
  localparam int AW    = 13;
  localparam int NR    = 2;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;
  int   cyc;

  int vectors;
  int miscompares;

  sram_nr1w_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) bus ();

  sram_nr1w #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .N_RD   (NR),
    .RD_LAT (LAT)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: word store as a sparse map (absent key = cleared word)
  logic [DW-1:0] mdl [int];

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q [NR][$];
  logic [DW-1:0] last_data [NR];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    return mdl.exists(int'(a)) ? mdl[int'(a)] : '0;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One request cycle while the memory is running
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NR-1:0] re, input logic [NR*AW-1:0] ra);
    exp_t e;
    logic [AW-1:0] a;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    for (int i = 0; i < NR; i++) begin
      if (re[i]) begin
        a = ra[i*AW +: AW];
        e.data = mdl_rd(a);
`ifdef SRAM_NR1W_BYPASS_EN
        if (we && wa == a) e.data = wd;
`endif
        e.cyc = cyc;
        q[i].push_back(e);
      end
    end
    if (we) mdl[int'(wa)] = wd;
    tick();
  endtask

  // Hold all read strobes high and junk writes during the clearing sweep;
  // returns the number of rising edges until ready is seen.
  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < DEPTH + 100) begin
      bus.rd_en   = '1;
      bus.rd_addr = {NR*AW{1'b0}} | {$urandom, $urandom};
      tick();
      n++;
    end
    mdl.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      q[i].delete();
      last_data[i] = '0;
    end
  endtask

  // Monitor: pops expectations whenever a port presents valid data
  exp_t          mon_e;
  logic [DW-1:0] mon_got;
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      mon_got = bus.rd_data[i*DW +: DW];
      if (bus.rd_valid[i] === 1'b1) begin
        if (q[i].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid port %0d: rd_valid=1 with no read outstanding (data %0h)", i, mon_got);
        end else begin
          mon_e = q[i].pop_front();
          chk($sformatf("rd_data[%0d]", i), mon_got, mon_e.data);
          chk($sformatf("latency[%0d]", i), DW'(cyc - mon_e.cyc), DW'(LAT));
        end
        last_data[i] = mon_got;
      end else begin
        chk($sformatf("hold[%0d]", i), mon_got, last_data[i]);
      end
    end
  end

  int n_init;

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < NR; i++) last_data[i] = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = '0;
    bus.rd_addr = '0;
    rst_n       = 1'b1;
    #1;
    do_reset();
    // Writes and reads presented during reset and the clearing sweep
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(3);
    bus.wr_data = DW'(8'hFF);
    bus.rd_en   = '1;
    tick();
    tick();
    chk("reset_ready", DW'(bus.ready), '0);
    chk("reset_valid", DW'(bus.rd_valid), '0);
    chk("reset_data", DW'(bus.rd_data), '0);
    rst_n = 1'b1;
    wait_ready(n_init);
    chk("init_cycles", DW'(n_init), DW'(DEPTH + 1));

    // Top address cleared, write during the sweep discarded
    drive(1'b0, '0, '0, 2'b11, {AW'(3), AW'(13'h1FFF)});
    chk("mdl_top_zero", mdl_rd(AW'(13'h1FFF)), '0);

    // Write then read on the next cycle
    drive(1'b1, AW'(5), DW'(32'hDEAD_BEEF), 2'b00, '0);
    drive(1'b0, '0, '0, 2'b01, {AW'(0), AW'(5)});

    // Back-to-back reads on both ports
    drive(1'b1, AW'(6), rnd_word(), 2'b00, '0);
    for (int k = 0; k < 10; k++) drive(1'b0, '0, '0, 2'b11, {AW'(6), AW'(5)});

    // Same-cycle write/read collision on a freshly cleared word
    drive(1'b1, AW'(9), DW'(16'h1234), 2'b11, {AW'(9), AW'(9)});
    drive(1'b0, '0, '0, 2'b01, {AW'(0), AW'(9)});

    // Random traffic over a small address window to force collisions
    for (int k = 0; k < 400; k++)
      drive(1'($urandom), AW'($urandom_range(0, 15)), rnd_word(),
            NR'($urandom), {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))});

    // Reset one cycle after a read issue drops it
    drive(1'b0, '0, '0, 2'b11, {AW'(5), AW'(6)});
    do_reset();
    #1;
    chk("midreset_ready", DW'(bus.ready), '0);
    chk("midreset_valid", DW'(bus.rd_valid), '0);
    chk("midreset_data", DW'(bus.rd_data), '0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_ready(n_init);
    chk("reinit_cycles", DW'(n_init), DW'(DEPTH + 1));

    // Previously written words are cleared by the second sweep
    drive(1'b0, '0, '0, 2'b11, {AW'(5), AW'(9)});
    drive(1'b0, '0, '0, 2'b11, {AW'(3), AW'(6)});

    for (int k = 0; k < LAT + 3; k++) drive(1'b0, '0, '0, 2'b00, '0);
    for (int i = 0; i < NR; i++)
      chk($sformatf("drain[%0d]", i), DW'(q[i].size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
